// File: rtl/fetch_queue_pkg.sv
// Shared MIPS front-end types: instruction/address words, the tagged fetch entry,
// and the default HALT encoding used to stop instruction fetch.
package mips_pkg;

    typedef logic [31:0] word_t;
    typedef logic [31:0] addr_t;

    typedef struct packed {
        word_t instr;
        addr_t pc;
    } fetch_entry_t;

    localparam word_t NOP_WORD          = 32'h0000_0000;
    localparam word_t DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    function automatic addr_t align_word(input addr_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake: the head of the fetch queue plus decode's accept signal.
interface fetch_queue_if;
    import mips_pkg::*;

    logic  dec_valid;
    word_t dec_instr;
    addr_t dec_pc;
    logic  dec_ready;

    modport master (output dec_valid, dec_instr, dec_pc, input dec_ready);
    modport slave  (input dec_valid, dec_instr, dec_pc, output dec_ready);

endinterface

// File: rtl/fq_fifo.sv
// Circular FIFO of fetch entries with synchronous flush; push and pop may coincide.
module fq_fifo
    import mips_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  fetch_entry_t  wdata_i,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // NOTE: storage needs no reset; an entry is only read once count says it was written.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = empty_o ? '{instr: NOP_WORD, pc: '0} : mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues to a 1-cycle imem, queues tagged words for decode.
// Optional FETCH_STATS_EN adds saturating fetch/flush/stall counters.
module fetch_queue
    import mips_pkg::*;
#(
    parameter int    DEPTH     = 4,
    parameter addr_t RESET_PC  = 32'h0000_0000,
    parameter word_t HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 imem_req,
    output addr_t                imem_addr,
    input  word_t                imem_rdata,
    input  logic                 redirect,
    input  addr_t                redirect_pc,
    fetch_queue_if.master        dec,
    output logic                 halted
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]          stat_fetched,
    output logic [15:0]          stat_flushes,
    output logic [31:0]          stat_stall_cycles
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    addr_t        pc_q, pc_d;
    addr_t        issued_pc_q, issued_pc_d;
    logic         inflight_q, inflight_d;
    logic         squash_q, squash_d;
    logic         halted_q, halted_d;

    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic          empty, full, pop, push, issue;
    fetch_entry_t  head;

    assign pop = ~empty & dec.dec_ready & ~redirect;

    // Credit check: entries queued plus the one returning, minus the one leaving now.
    assign occupancy = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign issue     = ~reset & ~redirect & ~halted_q & (occupancy < (CW+1)'(DEPTH));

    // Once halted, a word still returning was fetched past the HALT and is dropped.
    assign push = inflight_q & ~squash_q & ~redirect & ~halted_q & (~full | pop);

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        pc_d        = pc_q;
        issued_pc_d = issued_pc_q;
        inflight_d  = 1'b0;
        squash_d    = 1'b0;
        halted_d    = halted_q;
        if (redirect) begin
            pc_d     = align_word(redirect_pc);
            squash_d = 1'b1;
            halted_d = 1'b0;
        end else begin
            inflight_d = issue;
            if (issue) begin
                pc_d        = pc_q + 32'd4;
                issued_pc_d = pc_q;
            end
            if (push && imem_rdata == HALT_WORD) halted_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments only; next-state math lives above.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            issued_pc_q <= RESET_PC;
            inflight_q  <= 1'b0;
            squash_q    <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            issued_pc_q <= issued_pc_d;
            inflight_q  <= inflight_d;
            squash_q    <= squash_d;
            halted_q    <= halted_d;
        end
    end

    fq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect),
        .wdata_i ('{instr: imem_rdata, pc: issued_pc_q}),
        .head_o  (head),
        .count_o (count),
        .empty_o (empty),
        .full_o  (full)
    );

    assign imem_req      = issue;
    assign imem_addr     = pc_q;
    assign dec.dec_valid = ~empty;
    assign dec.dec_instr = head.instr;
    assign dec.dec_pc    = head.pc;
    assign halted        = halted_q;

`ifdef FETCH_STATS_EN
    logic [31:0] fetched_q;
    logic [15:0] flushes_q;
    logic [31:0] stalls_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_q <= '0;
            flushes_q <= '0;
            stalls_q  <= '0;
        end else begin
            if (push && fetched_q != '1)                      fetched_q <= fetched_q + 32'd1;
            if (redirect && flushes_q != '1)                  flushes_q <= flushes_q + 16'd1;
            if (~empty && ~dec.dec_ready && stalls_q != '1)   stalls_q  <= stalls_q + 32'd1;
        end
    end

    assign stat_fetched      = fetched_q;
    assign stat_flushes      = flushes_q;
    assign stat_stall_cycles = stalls_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random ready/redirect traffic, checked by a
// scoreboard fed from a stream model (PC sequence from each restart point up to the first HALT).
module tb_fetch_queue;
    import mips_pkg::*;

    localparam int    DEPTH     = 4;
    localparam addr_t RESET_PC  = 32'h0000_0000;
    localparam word_t HALT_WORD = 32'hFFFF_FFFF;

    logic  clk = 1'b0;
    logic  reset;
    logic  imem_req;
    addr_t imem_addr;
    word_t imem_rdata;
    logic  redirect;
    addr_t redirect_pc;
    logic  halted;
    fetch_queue_if dec_if ();
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched, stat_stall_cycles;
    logic [15:0] stat_flushes;
`endif

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .HALT_WORD(HALT_WORD)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dec         (dec_if),
        .halted      (halted)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched      (stat_fetched),
        .stat_flushes      (stat_flushes),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    issues;
    logic  halt_en;
    addr_t halt_addr;

    function automatic word_t mem_word(input addr_t a);
        return (halt_en && a == halt_addr) ? HALT_WORD : a;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // Instruction memory: one-cycle read latency, junk when not requested.
    always @(posedge clk) imem_rdata <= imem_req ? mem_word(imem_addr) : $urandom;

    // Reference stream model.
    fetch_entry_t exp_q[$];
    addr_t        gen_pc, exp_issue_pc;
    logic         gen_done;
    fetch_entry_t mon_e;

    task automatic top_up();
        fetch_entry_t e;
        while (!gen_done && exp_q.size() < 16) begin
            e.instr = mem_word(gen_pc);
            e.pc    = gen_pc;
            exp_q.push_back(e);
            if (e.instr == HALT_WORD) gen_done = 1'b1;
            gen_pc = gen_pc + 32'd4;
        end
    endtask

    task automatic model_restart(input addr_t start);
        exp_q.delete();
        gen_pc       = start;
        gen_done     = 1'b0;
        exp_issue_pc = start;
        top_up();
    endtask

    // Monitor: samples mid-cycle, compares against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            model_restart(RESET_PC);
        end else if (redirect) begin
            check("req_during_redirect", imem_req, 1'b0);
            model_restart(redirect_pc & ~32'h3);
        end else begin
            if (imem_req) begin
                check("issue_addr", imem_addr, exp_issue_pc);
                exp_issue_pc = exp_issue_pc + 32'd4;
            end
            if (dec_if.dec_valid && dec_if.dec_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_entry: got pc %h, required no entry", dec_if.dec_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("dec_instr", dec_if.dec_instr, mon_e.instr);
                    check("dec_pc", dec_if.dec_pc, mon_e.pc);
                    top_up();
                end
            end
            if (halted) check("req_while_halted", imem_req, 1'b0);
        end
        if (dec_if.dec_valid === 1'b0)
            check("empty_head_zero", {dec_if.dec_instr, dec_if.dec_pc}, 64'h0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; dec_if.dec_ready = 1'b0;
        halt_en = 1'b0; halt_addr = '0;
        step(); step(); mid();
        check("reset_dec_valid", dec_if.dec_valid, 1'b0);
        check("reset_imem_req", imem_req, 1'b0);
        check("reset_halted", halted, 1'b0);
        check("reset_imem_addr", imem_addr, RESET_PC);

        // Streaming: first entry two cycles after first issue, then no bubbles.
        step(); reset = 1'b0; dec_if.dec_ready = 1'b1; mid();
        check("c0_req", imem_req, 1'b1);
        check("c0_addr", imem_addr, 32'h0);
        check("c0_valid", dec_if.dec_valid, 1'b0);
        step(); mid();
        check("c1_valid", dec_if.dec_valid, 1'b0);
        check("c1_addr", imem_addr, 32'h4);
        step(); mid();
        check("c2_valid", dec_if.dec_valid, 1'b1);
        check("c2_pc", dec_if.dec_pc, 32'h0);
        for (int i = 0; i < 8; i++) begin
            step(); mid();
            check("no_bubble", dec_if.dec_valid, 1'b1);
        end

        // Stall: queue fills to DEPTH, issue stops, then drains and resumes at 16.
        step(); redirect = 1'b1; redirect_pc = 32'h0; dec_if.dec_ready = 1'b0;
        step(); redirect = 1'b0;
        issues = 0;
        for (int i = 0; i < 10; i++) begin
            mid();
            if (imem_req) issues++;
            step();
        end
        check("fill_issue_count", issues, DEPTH);
        check("full_no_req", imem_req, 1'b0);
        dec_if.dec_ready = 1'b1;
        mid();
        check("resume_req", imem_req, 1'b1);
        check("resume_addr", imem_addr, 32'h10);

        // Redirect with three queued entries, one in flight and decode accepting.
        step(); redirect = 1'b1; redirect_pc = 32'h0; dec_if.dec_ready = 1'b0;
        step(); redirect = 1'b0;
        repeat (3) step();
        mid();
        check("prefill_issue", imem_req, 1'b1);
        step(); redirect = 1'b1; redirect_pc = 32'h103; dec_if.dec_ready = 1'b1;
        mid();
        check("pre_flush_valid", dec_if.dec_valid, 1'b1);
        step(); redirect = 1'b0; mid();
        check("flush_valid_r1", dec_if.dec_valid, 1'b0);
        check("target_addr", imem_addr, 32'h100);
        step(); mid();
        check("flush_valid_r2", dec_if.dec_valid, 1'b0);
        step(); mid();
        check("target_valid_r3", dec_if.dec_valid, 1'b1);
        check("target_pc_r3", dec_if.dec_pc, 32'h100);

        // HALT at 0x8: 0,4,8 delivered, fetch stops; redirect clears it.
        step(); redirect = 1'b1; redirect_pc = 32'h0; halt_en = 1'b1; halt_addr = 32'h8;
        step(); redirect = 1'b0;
        repeat (12) step();
        mid();
        check("halted_set", halted, 1'b1);
        check("halted_no_req", imem_req, 1'b0);
        check("halted_drained", dec_if.dec_valid, 1'b0);
        step();
        check("halt_stream_done", exp_q.size(), 0);
        redirect = 1'b1; redirect_pc = 32'h40; halt_en = 1'b0;
        step(); redirect = 1'b0; mid();
        check("halt_cleared", halted, 1'b0);
        check("halt_resume_req", imem_req, 1'b1);
        check("halt_resume_addr", imem_addr, 32'h40);

        // Reset mid-stream.
        repeat (5) step();
        reset = 1'b1; mid();
        check("reset_cycle_req", imem_req, 1'b0);
        step(); mid();
        check("mid_reset_valid", dec_if.dec_valid, 1'b0);
        check("mid_reset_halted", halted, 1'b0);
        check("mid_reset_addr", imem_addr, RESET_PC);
        check("mid_reset_req", imem_req, 1'b0);
        step(); reset = 1'b0;

        // Random traffic, including PC wrap near 2^32 and random HALT placement.
        for (int i = 0; i < 3000; i++) begin
            step();
            dec_if.dec_ready = ($urandom_range(0, 9) < 7);
            redirect = ($urandom_range(0, 29) == 0);
            if (redirect) begin
                if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                else redirect_pc = $urandom;
                halt_en   = ($urandom_range(0, 2) == 0);
                halt_addr = (redirect_pc & ~32'h3) + 32'(4 * $urandom_range(0, 6));
            end
        end
        step(); redirect = 1'b0; dec_if.dec_ready = 1'b1;
        repeat (20) step();

`ifdef FETCH_STATS_EN
        // 10 fetches (0..0x24, HALT at 0x24), 1 redirect, 3 stall cycles.
        reset = 1'b1; dec_if.dec_ready = 1'b0; halt_en = 1'b1; halt_addr = 32'h24;
        step(); step();
        reset = 1'b0; redirect = 1'b1; redirect_pc = 32'h0;
        step(); redirect = 1'b0;
        repeat (5) step();
        dec_if.dec_ready = 1'b1;
        repeat (30) step();
        check("stat_fetched", stat_fetched, 32'd10);
        check("stat_flushes", stat_flushes, 16'd1);
        check("stat_stall_cycles", stat_stall_cycles, 32'd3);
        check("stat_halted", halted, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction-fetch front end that sits directly upstream of the decode stage of the MIPS pipeline. Owns the PC and issues word addresses to a synchronous instruction memory (1-cycle read latency). Buffers returned instructions, each tagged with its PC, in a small FIFO that decode drains through a valid/ready handshake. Supports branch/jump redirect with full flush, and a sticky halt-fetch on a programmable HALT word.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2; >=2 needed for 1 instr/cycle sustained)
RESET_PC, 32'h0000_0000, PC loaded on reset
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops further fetch

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
imem_req  out  1  read request this cycle
imem_addr  out  32  byte address (= PC register), word aligned
imem_rdata  in  32  instruction, valid the cycle after imem_req
redirect  in  1  branch/jump taken, from EX
redirect_pc  in  32  new PC; bits[1:0] ignored (forced 0)
dec_valid  out  1  FIFO head valid
dec_instr  out  32  head instruction
dec_pc  out  32  head PC
dec_ready  in  1  decode accepts head (low = stall)
halted  out  1  sticky: HALT_WORD has entered FIFO

Behaviour:
- Reset: pc=RESET_PC, count=0, inflight=0, halted=0, dec_valid=0, imem_req=0; dec_instr/dec_pc=0 when empty.
- Reset takes priority over every other input in the same cycle; a reset in mid-operation discards FIFO contents and in-flight data.
- pop = dec_valid & dec_ready & ~redirect.
- Issue rule: imem_req = ~redirect & ~halted & (count + inflight - pop < DEPTH). On issue: inflight<=1 and pc<=pc+4. Otherwise inflight<=0.
- Response: when inflight==1 and not squashed, push {imem_rdata, issued_pc} next edge; issued_pc is held in a register.
- Latency: address issued in cycle N; entry is visible at dec_valid in cycle N+2 (one cycle of memory latency plus one cycle for the FIFO write).
- Simultaneous push and pop: both occur and count is unchanged. The credit rule means push never happens when full.
- Redirect (highest priority after reset):
  - FIFO is cleared and dec_valid=0 in the next cycle.
  - pc<=redirect_pc&~3.
  - Any in-flight response returning in the next cycle is squashed via a squash flag.
  - halted is cleared.
  - No issue in the redirect cycle; the first fetch at the target goes out in cycle R+1 and its entry is visible in R+3.
- Halt: on push of imem_rdata==HALT_WORD, halted<=1 and issue stops. The HALT entry itself is still queued and delivered. Remaining FIFO entries still drain.
- Back-to-back redirects: the last one wins; each clears state again.
- Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits wide.
- PC arithmetic wraps modulo 2^32.

Optional Feature:
FETCH_STATS_EN.
- Defined: adds outputs stat_fetched[31:0] (incremented on every non-squashed push), stat_flushes[15:0] (incremented per redirect) and stat_stall_cycles[31:0] (incremented when dec_valid & ~dec_ready). All counters saturate at their maximum and are cleared by reset.
- Undefined: these ports and their logic are absent. Core behaviour is identical in both cases.

Decomposition:
- Shared package mips_pkg:
  - word_t (logic[31:0])
  - addr_t
  - fetch_entry_t struct {word_t instr; addr_t pc;}
  - constant NOP_WORD=32'h0
  - the default HALT_WORD value
- Sub-module fq_fifo (parameterised by DEPTH, storing fetch_entry_t):
  - inputs: push, pop, flush
  - outputs: head, count, empty, full
  - synchronous flush; simultaneous push and pop are legal.
- fetch_queue keeps the PC, inflight/squash/halted flags and the issue logic.

Test Plan:
- Reset, then dec_ready=1 and imem returning mem[a]=a: imem_addr goes 0,4,8… one per cycle. The first dec_valid appears 2 cycles after the first issue with pc=0, then one entry per cycle with no bubbles.
- Hold dec_ready=0: FIFO fills to DEPTH=4 and imem_req drops with no overflow. Release dec_ready: the 4 entries drain in order (pc 0,4,8,12) and fetch resumes at 16.
- Redirect to 0x100 while the FIFO holds 3 entries and one fetch is in flight:
  - next cycle dec_valid=0;
  - the squashed response is never seen;
  - the next delivered entry has pc=0x100, 3 cycles after the redirect.
- mem[0x8]=HALT_WORD: entries 0,4,8 are delivered, halted=1 and no further imem_req. A subsequent redirect to 0x40 clears halted and fetch resumes at 0x40.
- Redirect and dec_ready=1 with a valid head in the same cycle: the pop is suppressed (not counted) and the FIFO is cleared. Also apply reset mid-stream: all outputs return to their reset values on the next edge.
- With FETCH_STATS_EN defined, apply 10 fetches, 1 redirect and 3 stall cycles: stat_fetched=10, stat_flushes=1, stat_stall_cycles=3.
